// File: rtl/addsub_pkg.sv
// Shared types and helpers for the round-robin add/sub arbiter.
package addsub_pkg;

    // Response register occupancy.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    localparam int N_DEF    = 4;
    localparam int NREQ_DEF = 4;

    // Next round-robin pointer: the winner drops to lowest priority; no grant, no move.
    function automatic int rr_next(input int ptr, input int grant_idx,
                                   input logic granted, input int nreq);
        if (granted) begin
            return (grant_idx + 1) % nreq;
        end
        return ptr;
    endfunction

endpackage

// File: rtl/adder_subtractor.sv
// N-bit adder/subtractor; subtract is a + ~b + 1, cout = 1 means no borrow.
module adder_subtractor #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, sub};

endmodule

// File: rtl/addsub_arbiter_rr.sv
// Combinational round-robin picker: first set request scanning from ptr upward with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    logic [IDW-1:0] idx;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one adder_subtractor among NREQ valid/ready requesters with a registered,
// ID-tagged response channel and a saturating completed-operation counter.
//
// state     | meaning
// RSP_EMPTY | no result held; rsp_valid low, a grant loads the register
// RSP_FULL  | result held; consumed on rsp_ready, reloaded same cycle if granted
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREQ = NREQ_DEF,
    parameter  int CNTW = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][N-1:0]   req_a,
    input  logic [NREQ-1:0][N-1:0]   req_b,
    input  logic [NREQ-1:0]          req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [N-1:0]             rsp_sum,
    output logic                     rsp_cout,
    output logic [CNTW-1:0]          ops_done
);

    rsp_state_t      rsp_state;
    logic [IDW-1:0]  ptr;
    logic            slot_free;
    logic [NREQ-1:0] req_eligible;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic [N-1:0]    add_a;
    logic [N-1:0]    add_b;
    logic            add_sub;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    assign rsp_valid = (rsp_state == RSP_FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // Reset and a blocked response slot both hide every request from the arbiter.
    assign req_eligible = (!rst && slot_free) ? req_valid : '0;
    assign req_ready    = grant;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req         (req_eligible),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Steer the winner's operands to the shared datapath; idle inputs sit at zero.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (grant_valid) begin
            add_a   = req_a[grant_idx];
            add_b   = req_b[grant_idx];
            add_sub = req_sub[grant_idx];
        end
    end

    adder_subtractor #(
        .N (N)
    ) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Response register FSM, priority pointer and saturating consumption counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_state <= RSP_EMPTY;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            ptr       <= '0;
            ops_done  <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (ops_done != {CNTW{1'b1}})) begin
                ops_done <= ops_done + 1'b1;
            end

            ptr <= IDW'(rr_next(int'(ptr), int'(grant_idx), grant_valid, NREQ));

            case (rsp_state)
                RSP_EMPTY: begin
                    if (grant_valid) begin
                        rsp_state <= RSP_FULL;
                        rsp_id    <= grant_idx;
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                    end
                end
                RSP_FULL: begin
                    if (rsp_ready) begin
                        if (grant_valid) begin
                            rsp_id   <= grant_idx;
                            rsp_sum  <= add_sum;
                            rsp_cout <= add_cout;
                        end else begin
                            rsp_state <= RSP_EMPTY;
                        end
                    end
                end
                default: rsp_state <= RSP_EMPTY;
            endcase
        end
    end

endmodule
